gpio_disp_arbiter: RTL

Shares the 32-bit, 8-nibble hex-display output register between two write requesters: requester 0 (CPU GPIO write path) and requester 1 (debug/monitor source). It runs a req/ack handshake with per-nibble write masks, round-robin arbitration and a debug hold window. It also tracks which nibbles have ever been written, so the display drivers can blank untouched digits. It sits between the CPU's GPIO output path and the per-digit hex decoders.

---
 rtl/gpio_disp_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/gpio_disp_arbiter.sv
// gpio_disp_arbiter: shares the 8-nibble hex display register between the CPU
// GPIO write path (requester 0) and a debug/monitor source (requester 1).
// Requester 1 wins ties on alternate grants, and each of its writes holds
// requester 0 off for HOLD_CYCLES so the debug value stays visible.
module gpio_disp_arbiter #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] wdata0,
  input  logic [7:0]  wmask0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] wdata1,
  input  logic [7:0]  wmask1,
  output logic        ack1,
  output logic [31:0] disp_value,
  output logic [7:0]  digit_valid,
  output logic        owner,
  output logic        hold_busy
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = HOLD_CYCLES[CNT_W-1:0];

  logic [CNT_W-1:0] hold_cnt;
  logic             rr_ptr;
  logic             elig0;
  logic             elig1;
  logic             grant0;
  logic             grant1;
  logic [31:0]      win_data;
  logic [7:0]       win_mask;
  logic [31:0]      next_disp;

  assign hold_busy = (hold_cnt != '0);

  // Pick at most one winner; on a tie, the requester not granted last goes.
  always_comb begin
    elig0  = req0 & ~ack0 & ~hold_busy;
    elig1  = req1 & ~ack1;
    grant1 = elig1 & (~elig0 | ~rr_ptr);
    grant0 = elig0 & ~grant1;
  end

  // Merge the winner's masked nibbles into the current display value.
  always_comb begin
    win_data  = grant1 ? wdata1 : wdata0;
    win_mask  = grant1 ? wmask1 : wmask0;
    next_disp = disp_value;
    for (int k = 0; k < 8; k++) begin
      if (win_mask[k]) begin
        next_disp[4*k +: 4] = win_data[4*k +: 4];
      end
    end
  end

  // Display, ownership, ack pulses and round-robin pointer update on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_value  <= '0;
      digit_valid <= '0;
      owner       <= 1'b0;
      rr_ptr      <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
    end else begin
      ack0 <= grant0;
      ack1 <= grant1;
      if (grant0 | grant1) begin
        disp_value  <= next_disp;
        digit_valid <= digit_valid | win_mask;
        owner       <= grant1;
        rr_ptr      <= grant1;
      end
    end
  end

  // Hold window: reload on every requester-1 grant, otherwise count down to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (grant1) begin
      hold_cnt <= HOLD_LOAD;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - CNT_W'(1);
    end
  end

endmodule
